mult_bw_pipe_hs: RTL and testbench

- Next-generation pipelined Baugh-Wooley row-adder-tree multiplier for the ALU parts library.
- Adds per-transaction signed/unsigned selection for each operand and a valid/ready handshake with backpressure (stall).
- Adds a tag sideband that travels with each product.
- Fully pipelined: one product per cycle when out_ready stays high, with any number of operations in flight.

---
 rtl/mult_bw_pipe_hs_if.sv | 29 ++
 rtl/mult_bw_pipe_hs.sv | 114 +++++++++++
 tb/tb_mult_bw_pipe_hs.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_bw_pipe_hs_if.sv
// Handshake bundle for the pipelined Baugh-Wooley multiplier: operand/mode/tag
// input channel and product/tag output channel.
interface mult_bw_pipe_hs_if #(
   parameter int A_WIDTH   = 24,
   parameter int B_WIDTH   = 24,
   parameter int TAG_WIDTH = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic [A_WIDTH-1:0]           in_a;
   logic [B_WIDTH-1:0]           in_b;
   logic                         in_a_signed;
   logic                         in_b_signed;
   logic [TAG_WIDTH-1:0]         in_tag;
   logic                         out_valid;
   logic                         out_ready;
   logic [A_WIDTH+B_WIDTH-1:0]   out_c;
   logic [TAG_WIDTH-1:0]         out_tag;

   modport master (
      output in_valid, in_a, in_b, in_a_signed, in_b_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_c, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_a_signed, in_b_signed, in_tag, out_ready,
      output in_ready, out_valid, out_c, out_tag
   );
endinterface

// File: rtl/mult_bw_pipe_hs.sv
// Pipelined modified Baugh-Wooley multiplier with per-operand signedness,
// valid/ready handshake with whole-pipeline stall, and a tag sideband.
module mult_bw_pipe_hs #(
   parameter int A_WIDTH   = 24,
   parameter int B_WIDTH   = 24,
   parameter int TAG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   mult_bw_pipe_hs_if.slave bus
);
   localparam int SW  = ((A_WIDTH < B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;
   localparam int LW  = ((A_WIDTH < B_WIDTH) ? B_WIDTH : A_WIDTH) + 1;
   localparam int L   = $clog2(SW);
   localparam int LAT = L + 1;
   localparam int PW  = LW + SW;
   localparam int CW  = A_WIDTH + B_WIDTH;
   localparam logic [PW-1:0] CORR = (PW'(1) << (LW - 1)) + (PW'(1) << (SW - 1));

   // Rows left after k tree layers: ceil(SW / 2^k).
   function automatic int nrows(input int k);
      return (SW + (1 << k) - 1) >> k;
   endfunction

   logic                 en;
   logic                 take;
   logic [LW-1:0]        long_ext;
   logic [SW-1:0]        short_ext;
   logic [LW-1:0]        long_reg;
   logic [SW-1:0]        short_reg;
   logic                 vld_reg [0:LAT];
   logic [TAG_WIDTH-1:0] tag_reg [0:LAT];
   logic [PW-1:0]        final_row;
   logic                 unused_msbs;

   assign en           = ~vld_reg[LAT] | bus.out_ready;
   assign bus.in_ready = en & resetn;
   assign take         = bus.in_valid & bus.in_ready;

   // The wider operand always feeds the LW-bit side of the array.
   generate
      if (A_WIDTH >= B_WIDTH) begin : g_a_long
         assign long_ext  = {bus.in_a_signed & bus.in_a[A_WIDTH-1], bus.in_a};
         assign short_ext = {bus.in_b_signed & bus.in_b[B_WIDTH-1], bus.in_b};
      end else begin : g_b_long
         assign long_ext  = {bus.in_b_signed & bus.in_b[B_WIDTH-1], bus.in_b};
         assign short_ext = {bus.in_a_signed & bus.in_a[A_WIDTH-1], bus.in_a};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         long_reg  <= '0;
         short_reg <= '0;
         for (int s = 0; s <= LAT; s++) begin
            vld_reg[s] <= 1'b0;
            tag_reg[s] <= '0;
         end
      end else if (en) begin
         long_reg   <= long_ext;
         short_reg  <= short_ext;
         vld_reg[0] <= take;
         tag_reg[0] <= bus.in_tag;
         for (int s = 1; s <= LAT; s++) begin
            vld_reg[s] <= vld_reg[s-1];
            tag_reg[s] <= tag_reg[s-1];
         end
      end
   end

   // Layer 0 holds unshifted partial-product rows (row i weighs 2^i); each
   // later layer folds row pairs, so row j of layer k weighs 2^(j*2^k).
   genvar gi, gj;
   generate
      for (gi = 0; gi <= L; gi++) begin : g_layer
         localparam int NR = nrows(gi);
         localparam logic [PW-1:0] ADD_C = (gi == L) ? CORR : {PW{1'b0}};
         logic [PW-1:0] rows_next [0:NR-1];
         logic [PW-1:0] rows_reg  [0:NR-1];

         for (gj = 0; gj < NR; gj++) begin : g_row
            if (gi == 0) begin : g_pp
               localparam logic [LW-1:0] INV = (gj == SW - 1) ?
                  ({LW{1'b1}} >> 1) : {1'b1, {(LW-1){1'b0}}};
               localparam logic [PW-1:0] ONE_BIT = (gj == SW - 1) ?
                  (PW'(1) << LW) : {PW{1'b0}};
               assign rows_next[gj] =
                  {{SW{1'b0}}, (long_reg & {LW{short_reg[gj]}}) ^ INV} | ONE_BIT;
            end else if (2 * gj + 1 < nrows(gi - 1)) begin : g_add
               assign rows_next[gj] = g_layer[gi-1].rows_reg[2*gj]
                  + (g_layer[gi-1].rows_reg[2*gj+1] << (1 << (gi - 1)))
                  + ADD_C;
            end else begin : g_fwd
               assign rows_next[gj] = g_layer[gi-1].rows_reg[2*gj] + ADD_C;
            end
         end

         always_ff @(posedge clk) begin
            if (!resetn) begin
               for (int r = 0; r < NR; r++) rows_reg[r] <= '0;
            end else if (en) begin
               for (int r = 0; r < NR; r++) rows_reg[r] <= rows_next[r];
            end
         end
      end
   endgenerate

   assign final_row     = g_layer[L].rows_reg[0];
   assign bus.out_c     = final_row[CW-1:0];
   assign bus.out_tag   = tag_reg[LAT];
   assign bus.out_valid = vld_reg[LAT];
   // The two bits above the product width only carry modular wrap-around.
   assign unused_msbs   = ^final_row[PW-1:CW];
endmodule

// File: tb/tb_mult_bw_pipe_hs.sv
// Directed, table-driven and random checks for mult_bw_pipe_hs at 8x5 bits.
module tb_mult_bw_pipe_hs;
   localparam int AW = 8;
   localparam int BW = 5;
   localparam int TW = 4;
   localparam int CW = AW + BW;

   typedef struct {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic          as;
      logic          bs;
      logic [TW-1:0] tag;
      logic [CW-1:0] c;
   } vec_t;

   typedef struct {
      logic [CW-1:0] c;
      logic [TW-1:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_pop = 0;
   int   cyc   = 0;
   logic [CW-1:0] cur_c;
   logic [TW-1:0] cur_tag;
   exp_t exp_q[$];
   int   pop_cyc_q[$];
   bit   rnd_on;

   mult_bw_pipe_hs_if #(.A_WIDTH(AW), .B_WIDTH(BW), .TAG_WIDTH(TW)) bus ();

   mult_bw_pipe_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TAG_WIDTH(TW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                           input logic as, input logic bs);
      longint va, vb;
      logic [63:0] p;
      va = longint'(a);
      vb = longint'(b);
      if (as && a[AW-1]) va = va - (64'sd1 <<< AW);
      if (bs && b[BW-1]) vb = vb - (64'sd1 <<< BW);
      p = 64'(va * vb);
      return p[CW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic as,
                       input logic bs, input logic [TW-1:0] tag, input logic [CW-1:0] c);
      bit acc;
      int guard;
      bus.in_a        = a;
      bus.in_b        = b;
      bus.in_a_signed = as;
      bus.in_b_signed = bs;
      bus.in_tag      = tag;
      cur_c           = c;
      cur_tag         = tag;
      bus.in_valid    = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         guard++;
         if (!acc && guard > 200) begin
            check("accept_timeout", 32'(guard), 32'd0);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 80) begin
         tick();
         guard++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: expectations enter on the accepting cycle, leave on output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            exp_q.delete();
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 32'(bus.out_tag), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  n_pop++;
                  pop_cyc_q.push_back(cyc);
                  $display("txn %0d: out_c=%h out_tag=%h (want %h/%h)",
                           n_pop, bus.out_c, bus.out_tag, e.c, e.tag);
                  check("out_c", 32'(bus.out_c), 32'(e.c));
                  check("out_tag", 32'(bus.out_tag), 32'(e.tag));
               end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back('{c: cur_c, tag: cur_tag});
         end
      end
   end

   initial begin
      vec_t vt [12];
      logic [CW-1:0] hold_c;
      logic [TW-1:0] hold_tag;
      int            pops_before;
      int            g;

      vt[0]  = '{a: 8'h80, b: 5'h10, as: 1, bs: 1, tag: 4'h3, c: 13'h0800};
      vt[1]  = '{a: 8'hFF, b: 5'h1F, as: 0, bs: 0, tag: 4'h5, c: 13'h1EE1};
      vt[2]  = '{a: 8'hFF, b: 5'h1F, as: 1, bs: 0, tag: 4'h6, c: 13'h1FE1};
      vt[3]  = '{a: 8'hC8, b: 5'h10, as: 0, bs: 1, tag: 4'h7, c: 13'h1380};
      vt[4]  = '{a: 8'h00, b: 5'h1B, as: 1, bs: 1, tag: 4'h8, c: 13'h0000};
      vt[5]  = '{a: 8'h7F, b: 5'h0F, as: 1, bs: 1, tag: 4'h9, c: 13'h0771};
      vt[6]  = '{a: 8'h80, b: 5'h1F, as: 1, bs: 0, tag: 4'hA, c: 13'h1080};
      vt[7]  = '{a: 8'h80, b: 5'h10, as: 0, bs: 1, tag: 4'hB, c: 13'h1800};
      vt[8]  = '{a: 8'hFF, b: 5'h1F, as: 0, bs: 1, tag: 4'hC, c: 13'h1F01};
      vt[9]  = '{a: 8'h01, b: 5'h01, as: 0, bs: 0, tag: 4'hD, c: 13'h0001};
      vt[10] = '{a: 8'h80, b: 5'h1F, as: 1, bs: 1, tag: 4'hE, c: 13'h0080};
      vt[11] = '{a: 8'h7F, b: 5'h10, as: 1, bs: 1, tag: 4'hF, c: 13'h1810};

      resetn          = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_a        = '0;
      bus.in_b        = '0;
      bus.in_a_signed = 1'b0;
      bus.in_b_signed = 1'b0;
      bus.in_tag      = '0;
      bus.out_ready   = 1'b1;
      cur_c           = '0;
      cur_tag         = '0;
      repeat (3) tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_c", 32'(bus.out_c), 32'd0);
      check("rst_out_tag", 32'(bus.out_tag), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      resetn = 1'b1;
      tick();

      // Latency: accepted at edge n, out_valid must rise exactly after edge n+4.
      bus.in_a = vt[0].a; bus.in_b = vt[0].b;
      bus.in_a_signed = vt[0].as; bus.in_b_signed = vt[0].bs;
      bus.in_tag = vt[0].tag; cur_c = vt[0].c; cur_tag = vt[0].tag;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("lat_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("lat_early_valid", 32'(bus.out_valid), 32'd0);
      end
      tick();
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      drain();

      // Back-to-back table stream; results must leave on consecutive cycles.
      pop_cyc_q.delete();
      for (int i = 1; i < 12; i++) begin
         check("table_model", 32'(model(vt[i].a, vt[i].b, vt[i].as, vt[i].bs)), 32'(vt[i].c));
         send(vt[i].a, vt[i].b, vt[i].as, vt[i].bs, vt[i].tag, vt[i].c);
      end
      drain();
      if (pop_cyc_q.size() == 11)
         check("stream_gapless", 32'(pop_cyc_q[10] - pop_cyc_q[0]), 32'd10);
      else
         check("stream_count", 32'(pop_cyc_q.size()), 32'd11);

      // Backpressure: stall 3 cycles as soon as the first of 6 results shows.
      pops_before = n_pop;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(8'(8'h93 + 8'(i * 29)), 5'(5'h0B + 5'(i * 7)), i[0], i[1],
                    4'(i + 1), model(8'(8'h93 + 8'(i * 29)), 5'(5'h0B + 5'(i * 7)), i[0], i[1]));
         end
         begin
            g = 0;
            do begin
               tick();
               g++;
            end while (!bus.out_valid && g < 50);
            check("bp_first_valid", 32'(bus.out_valid), 32'd1);
            bus.out_ready = 1'b0;
            hold_c   = bus.out_c;
            hold_tag = bus.out_tag;
            repeat (3) begin
               tick();
               check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
               check("bp_hold_c", 32'(bus.out_c), 32'(hold_c));
               check("bp_hold_tag", 32'(bus.out_tag), 32'(hold_tag));
               check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("bp_result_count", 32'(n_pop - pops_before), 32'd6);

      // Reset mid-flight: three accepted ops must vanish without trace.
      for (int i = 0; i < 3; i++)
         send(8'h11 + 8'(i), 5'h03, 1'b0, 1'b0, 4'(i + 1), model(8'h11 + 8'(i), 5'h03, 1'b0, 1'b0));
      resetn = 1'b0;
      tick();
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_out_c", 32'(bus.out_c), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      resetn = 1'b1;
      g = 0;
      repeat (10) begin
         tick();
         if (bus.out_valid) g++;
      end
      check("mid_rst_stale", 32'(g), 32'd0);
      send(8'hF0, 5'h11, 1'b1, 1'b1, 4'h9, model(8'hF0, 5'h11, 1'b1, 1'b1));
      drain();

      // Random sweep with random backpressure and input gaps.
      rnd_on = 1'b1;
      pops_before = n_pop;
      fork
         begin
            logic [AW-1:0] ra;
            logic [BW-1:0] rb;
            logic          ras, rbs;
            for (int i = 0; i < 10000; i++) begin
               ra  = AW'($urandom);
               rb  = BW'($urandom);
               ras = 1'($urandom_range(0, 1));
               rbs = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) tick();
               send(ra, rb, ras, rbs, TW'(i), model(ra, rb, ras, rbs));
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               tick();
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();
      check("rnd_result_count", 32'(n_pop - pops_before), 32'd10000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
